thread_sched: RTL and testbench
===============================

THREAD_SCHED -- requirements
Module: thread_sched

Interface
REQ-001 SHALL have parameter PC_W, default 16, meaning the program-counter width.
REQ-002 SHALL have parameter PC_STEP, default 2, meaning the per-issue PC increment.
REQ-003 SHALL have parameter T0_START, default 0, meaning the thread-0 reset PC.
REQ-004 SHALL have parameter T1_START, default 1, meaning the thread-1 reset PC.
REQ-005 SHALL have port clk  in  1  single clock, all state updates on posedge.
REQ-006 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have port issue_ready  in  1  pipeline accepts an issue slot this cycle.
REQ-008 SHALL have port issue_valid  out  1  an instruction fetch is offered.
REQ-009 SHALL have port issue_tid  out  1  thread owning the offered slot.
REQ-010 SHALL have port issue_pc  out  PC_W  fetch address of the offered slot.
REQ-011 SHALL have ports redir_valid  in  1, redir_tid  in  1 and redir_pc  in  PC_W, which carry a resolved jump/call/ret target.
REQ-012 SHALL have ports stall_set  in  2 and stall_clr  in  2, per thread, which start and end a load wait.
REQ-013 SHALL have port halt_req  in  2  per-thread sys/halt retired.
REQ-014 SHALL have port halted  out  2  per-thread halted status.
REQ-015 SHALL have port halt  out  1  all threads halted.

Function
REQ-016 Each thread SHALL hold a PC and a state in {RUN, STALL, HALT}; a thread is eligible only in RUN.
REQ-017 issue_valid, issue_tid and issue_pc SHALL be combinational from registered state (zero-cycle offer); an issue occurs when issue_valid and issue_ready are both high.
REQ-018 On an issue, the issuing thread's PC SHALL advance by PC_STEP modulo 2^PC_W (0xFFFE+2 wraps to 0x0000).
REQ-019 Selection SHALL prefer the thread other than last_tid; last_tid updates to issue_tid on each issue.
REQ-020 A redirect SHALL load redir_pc into the thread's PC at the next edge; if it coincides with an issue of the same thread, the redirect value wins.
REQ-021 A redirect to a thread in HALT SHALL be ignored; a redirect to a thread in STALL SHALL update its PC without changing its state.
REQ-022 Transitions: RUN->STALL on stall_set; STALL->RUN on stall_clr; any->HALT on halt_req; HALT is exited only by reset.
REQ-023 Simultaneous events SHALL resolve as: halt_req beats stall_set/stall_clr/redirect, and stall_set beats stall_clr.
REQ-024 stall_clr in RUN and stall_set in HALT SHALL have no effect.
REQ-025 halted[i] SHALL be high when thread i is in HALT; halt SHALL be registered high one cycle after both threads are in HALT.
REQ-026 With no eligible thread, issue_valid SHALL be 0 and issue_tid/issue_pc SHALL hold their last values.

Reset
REQ-027 When reset=0 at a posedge: pc0=T0_START, pc1=T1_START, both threads in RUN, last_tid=1 (thread 0 issues first), halted=2'b00, halt=0.
REQ-028 Reset SHALL abort any in-progress stall or halt; inputs SHALL be ignored during the reset cycle.

Configuration
REQ-029 Macro SCHED_SKIP_EN defined: if the preferred thread is ineligible, the other eligible thread SHALL issue in the same cycle.
REQ-030 SCHED_SKIP_EN undefined: strict alternation; the slot pointer SHALL toggle every cycle issue_ready=1, and an ineligible owner SHALL yield issue_valid=0 (bubble).

Structure
REQ-031 The shared package sik_pkg SHALL hold PC_W, the thread state encoding (RUN/STALL/HALT), and the existing opcode constants.
REQ-032 Per-thread PC and state SHALL live in sub-module thread_ctx, instantiated twice; the arbitration logic SHALL reside in thread_sched.

Verification
REQ-033 Reset, issue_ready=1 for 4 cycles -> tid/pc sequence 0/0, 1/1, 0/2, 1/3.
REQ-034 stall_set=2'b01 after first issue, with SCHED_SKIP_EN -> thread 1 issues every cycle (pc 1,3,5); stall_clr=2'b01 -> alternation resumes with thread 0 at pc 2.
REQ-035 The same stimulus without SCHED_SKIP_EN -> issue_valid=0 on every thread-0 slot while stalled.
REQ-036 Redirect tid0 to 0x0100 in the same cycle thread 0 issues at 0x0004 -> next thread-0 issue_pc=0x0100.
REQ-037 halt_req=2'b01 together with redir_valid for tid0 -> halted=2'b01 and thread 0 never issues again; halt_req=2'b10 -> halt=1 one cycle later and issue_valid=0.
REQ-038 pc0 forced to 0xFFFE by redirect, then one issue -> next thread-0 issue_pc=0x0000.

Source files
------------

// File: rtl/sik_pkg.sv
// Shared definitions for the fetch scheduler: PC width, thread state encoding, opcodes.
// Combinational content only; no latency or backpressure.
package sik_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    TS_RUN   = 2'd0,
    TS_STALL = 2'd1,
    TS_HALT  = 2'd2
  } tstate_t;

  localparam logic [5:0] OP_JMP  = 6'h02;
  localparam logic [5:0] OP_CALL = 6'h03;
  localparam logic [5:0] OP_RET  = 6'h04;
  localparam logic [5:0] OP_LD   = 6'h08;
  localparam logic [5:0] OP_SYS  = 6'h3f;

endpackage

// File: rtl/thread_ctx.sv
// Per-thread context: program counter plus RUN/STALL/HALT state.
// Updates on the edge after an event; eligible/halted are straight decodes of registered state.
module thread_ctx
  import sik_pkg::*;
#(
  parameter int              PC_W    = sik_pkg::PC_W,
  parameter int              PC_STEP = 2,
  parameter logic [PC_W-1:0] START   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue,
  input  logic            redir,
  input  logic [PC_W-1:0] redir_pc,
  input  logic            stall_set,
  input  logic            stall_clr,
  input  logic            halt_req,
  output logic [PC_W-1:0] pc,
  output logic            eligible,
  output logic            halted
);

  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  tstate_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!reset) state <= TS_RUN;
    else        state <= state_nxt;
  end

  // halt_req outranks everything; within STALL a fresh stall_set outranks stall_clr
  always_comb begin
    state_nxt = state;
    if (halt_req) begin
      state_nxt = TS_HALT;
    end else begin
      case (state)
        TS_RUN:   if (stall_set) state_nxt = TS_STALL;
        TS_STALL: if (!stall_set && stall_clr) state_nxt = TS_RUN;
        default:  state_nxt = TS_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= START;
    end else if (redir && state != TS_HALT && !halt_req) begin
      pc <= redir_pc;
    end else if (issue) begin
      pc <= pc + STEP;
    end
  end

  assign eligible = (state == TS_RUN);
  assign halted   = (state == TS_HALT);

endmodule

// File: rtl/thread_sched.sv
// Two-thread fetch scheduler; offers one fetch slot per cycle, zero-cycle combinational offer.
// A slot is consumed only when issue_ready is high; SCHED_SKIP_EN lets the other thread fill an ineligible slot.
module thread_sched
  import sik_pkg::*;
#(
  parameter int              PC_W     = sik_pkg::PC_W,
  parameter int              PC_STEP  = 2,
  parameter logic [PC_W-1:0] T0_START = '0,
  parameter logic [PC_W-1:0] T1_START = {{(PC_W-1){1'b0}}, 1'b1}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_ready,
  output logic            issue_valid,
  output logic            issue_tid,
  output logic [PC_W-1:0] issue_pc,
  input  logic            redir_valid,
  input  logic            redir_tid,
  input  logic [PC_W-1:0] redir_pc,
  input  logic [1:0]      stall_set,
  input  logic [1:0]      stall_clr,
  input  logic [1:0]      halt_req,
  output logic [1:0]      halted,
  output logic            halt
);

  logic [PC_W-1:0] pc [2];
  logic [1:0]      elig;
  logic            last_tid;
  logic            pref;
  logic            sel_tid;
  logic            hold_tid;
  logic [PC_W-1:0] hold_pc;
  logic            fire;

  for (genvar i = 0; i < 2; i++) begin : g_ctx
    thread_ctx #(
      .PC_W    (PC_W),
      .PC_STEP (PC_STEP),
      .START   ((i == 0) ? T0_START : T1_START)
    ) u_ctx (
      .clk       (clk),
      .reset     (reset),
      .issue     (fire && (issue_tid == 1'(i))),
      .redir     (redir_valid && (redir_tid == 1'(i))),
      .redir_pc  (redir_pc),
      .stall_set (stall_set[i]),
      .stall_clr (stall_clr[i]),
      .halt_req  (halt_req[i]),
      .pc        (pc[i]),
      .eligible  (elig[i]),
      .halted    (halted[i])
    );
  end

  assign pref = ~last_tid;

  always_comb begin
`ifdef SCHED_SKIP_EN
    sel_tid     = elig[pref] ? pref : ~pref;
    issue_valid = |elig;
`else
    sel_tid     = pref;
    issue_valid = elig[pref];
`endif
    // with no offer the slot outputs freeze on the last offered values
    issue_tid = issue_valid ? sel_tid : hold_tid;
    issue_pc  = issue_valid ? pc[sel_tid] : hold_pc;
  end

  assign fire = issue_valid && issue_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_tid <= 1'b1;
      hold_tid <= 1'b0;
      hold_pc  <= T0_START;
      halt     <= 1'b0;
    end else begin
      hold_tid <= issue_tid;
      hold_pc  <= issue_pc;
      halt     <= &halted;
`ifdef SCHED_SKIP_EN
      if (fire) last_tid <= issue_tid;
`else
      // strict alternation: the slot pointer moves on every ready cycle, issued or bubbled
      if (issue_ready) last_tid <= ~last_tid;
`endif
    end
  end

endmodule

// File: tb/tb_thread_sched.sv
// Directed self-checking bench for thread_sched; expectations follow SCHED_SKIP_EN when defined.
module tb_thread_sched;

  localparam int PC_W = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            issue_ready = 1'b0;
  logic            issue_valid;
  logic            issue_tid;
  logic [PC_W-1:0] issue_pc;
  logic            redir_valid = 1'b0;
  logic            redir_tid = 1'b0;
  logic [PC_W-1:0] redir_pc = '0;
  logic [1:0]      stall_set = 2'b00;
  logic [1:0]      stall_clr = 2'b00;
  logic [1:0]      halt_req = 2'b00;
  logic [1:0]      halted;
  logic            halt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thread_sched #(
    .PC_W     (PC_W),
    .PC_STEP  (2),
    .T0_START (16'h0000),
    .T1_START (16'h0001)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_ready (issue_ready),
    .issue_valid (issue_valid),
    .issue_tid   (issue_tid),
    .issue_pc    (issue_pc),
    .redir_valid (redir_valid),
    .redir_tid   (redir_tid),
    .redir_pc    (redir_pc),
    .stall_set   (stall_set),
    .stall_clr   (stall_clr),
    .halt_req    (halt_req),
    .halted      (halted),
    .halt        (halt)
  );

  task automatic clear_inputs();
    issue_ready = 1'b0;
    redir_valid = 1'b0;
    redir_tid   = 1'b0;
    redir_pc    = '0;
    stall_set   = 2'b00;
    stall_clr   = 2'b00;
    halt_req    = 2'b00;
  endtask

  // returns at a negedge with fresh post-reset state on the outputs
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset       = 1'b0;
    issue_ready = 1'b1;
    stall_set   = 2'b11;
    halt_req    = 2'b11;
    redir_valid = 1'b1;
    redir_pc    = 16'h1234;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({issue_valid, issue_tid, issue_pc} !== {1'b1, 1'b0, 16'h0000}) begin
      n_bad++;
      $display("FAIL reset_offer: got v=%b tid=%b pc=%h, want v=1 tid=0 pc=0000", issue_valid, issue_tid, issue_pc);
    end
    n_cmp++;
    if (halted !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_halted: got %b, want 00", halted);
    end
    n_cmp++;
    if (halt !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_halt: got %b, want 0", halt);
    end
    clear_inputs();
    reset = 1'b1;
  endtask

  task automatic test_sequence();
    logic [17:0] e [$];
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b1, 16'h0001},
          {1'b1, 1'b0, 16'h0002}, {1'b1, 1'b1, 16'h0003}};
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      n_cmp++;
      if ({issue_valid, issue_tid, issue_pc} !== e[i]) begin
        n_bad++;
        $display("FAIL sequence cyc %0d: got v=%b tid=%b pc=%h, want v=%b tid=%b pc=%h",
                 i, issue_valid, issue_tid, issue_pc, e[i][17], e[i][16], e[i][15:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [17:0] e [$];
    int clr_cyc;
`ifdef SCHED_SKIP_EN
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b1, 16'h0001}, {1'b1, 1'b1, 16'h0003},
          {1'b1, 1'b1, 16'h0005}, {1'b1, 1'b0, 16'h0002}};
    clr_cyc = 3;
`else
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b1, 16'h0001}, {1'b0, 1'b1, 16'h0001},
          {1'b1, 1'b1, 16'h0003}, {1'b0, 1'b1, 16'h0003}, {1'b1, 1'b1, 16'h0005},
          {1'b1, 1'b0, 16'h0002}};
    clr_cyc = 5;
`endif
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      stall_set = (i == 0) ? 2'b01 : 2'b00;
      stall_clr = (i == clr_cyc) ? 2'b01 : 2'b00;
      n_cmp++;
      if ({issue_valid, issue_tid, issue_pc} !== e[i]) begin
        n_bad++;
        $display("FAIL stall cyc %0d: got v=%b tid=%b pc=%h, want v=%b tid=%b pc=%h",
                 i, issue_valid, issue_tid, issue_pc, e[i][17], e[i][16], e[i][15:0]);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_redirect();
    logic [17:0] e [$];
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b1, 16'h0001}, {1'b1, 1'b0, 16'h0002},
          {1'b1, 1'b1, 16'h0003}, {1'b1, 1'b0, 16'h0004}, {1'b1, 1'b1, 16'h0005},
          {1'b1, 1'b0, 16'h0100}};
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      redir_valid = (i == 4);
      redir_tid   = 1'b0;
      redir_pc    = 16'h0100;
      n_cmp++;
      if ({issue_valid, issue_tid, issue_pc} !== e[i]) begin
        n_bad++;
        $display("FAIL redirect cyc %0d: got v=%b tid=%b pc=%h, want v=%b tid=%b pc=%h",
                 i, issue_valid, issue_tid, issue_pc, e[i][17], e[i][16], e[i][15:0]);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    logic [17:0] e [$];
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b0, 16'hFFFE},
          {1'b1, 1'b1, 16'h0001}, {1'b1, 1'b0, 16'h0000}};
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      issue_ready = (i != 0);
      redir_valid = (i == 0);
      redir_tid   = 1'b0;
      redir_pc    = 16'hFFFE;
      n_cmp++;
      if ({issue_valid, issue_tid, issue_pc} !== e[i]) begin
        n_bad++;
        $display("FAIL wrap cyc %0d: got v=%b tid=%b pc=%h, want v=%b tid=%b pc=%h",
                 i, issue_valid, issue_tid, issue_pc, e[i][17], e[i][16], e[i][15:0]);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  // simultaneous stall_set/stall_clr on thread 0 leaves it stalled; stall_clr on running thread 1 is inert
  task automatic test_priority();
    logic [17:0] e [$];
`ifdef SCHED_SKIP_EN
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b1, 16'h0001}, {1'b1, 1'b1, 16'h0003}};
`else
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b0, 1'b0, 16'h0000}, {1'b1, 1'b1, 16'h0001}};
`endif
    do_reset();
    for (int i = 0; i < e.size(); i++) begin
      issue_ready = (i != 0);
      stall_set   = (i == 0) ? 2'b01 : 2'b00;
      stall_clr   = (i == 0) ? 2'b11 : 2'b00;
      n_cmp++;
      if ({issue_valid, issue_tid, issue_pc} !== e[i]) begin
        n_bad++;
        $display("FAIL priority cyc %0d: got v=%b tid=%b pc=%h, want v=%b tid=%b pc=%h",
                 i, issue_valid, issue_tid, issue_pc, e[i][17], e[i][16], e[i][15:0]);
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    logic [17:0] e [$];
`ifdef SCHED_SKIP_EN
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b1, 16'h0001}, {1'b1, 1'b1, 16'h0003},
          {1'b1, 1'b1, 16'h0005}, {1'b1, 1'b1, 16'h0007}, {1'b1, 1'b1, 16'h0009},
          {1'b0, 1'b1, 16'h0009}, {1'b0, 1'b1, 16'h0009}};
`else
    e = '{{1'b1, 1'b0, 16'h0000}, {1'b1, 1'b1, 16'h0001}, {1'b0, 1'b1, 16'h0001},
          {1'b1, 1'b1, 16'h0003}, {1'b0, 1'b1, 16'h0003}, {1'b1, 1'b1, 16'h0005},
          {1'b0, 1'b1, 16'h0005}, {1'b0, 1'b1, 16'h0005}};
`endif
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < e.size(); i++) begin
      halt_req    = (i == 0) ? 2'b01 : (i == 5) ? 2'b10 : 2'b00;
      redir_valid = (i == 0);
      redir_tid   = 1'b0;
      redir_pc    = 16'h0200;
      stall_clr   = (i == 3) ? 2'b01 : 2'b00;
      n_cmp++;
      if ({issue_valid, issue_tid, issue_pc} !== e[i]) begin
        n_bad++;
        $display("FAIL halt_offer cyc %0d: got v=%b tid=%b pc=%h, want v=%b tid=%b pc=%h",
                 i, issue_valid, issue_tid, issue_pc, e[i][17], e[i][16], e[i][15:0]);
      end
      if (i == 1) begin
        n_cmp++;
        if (halted !== 2'b01) begin
          n_bad++;
          $display("FAIL halted_t0: got %b, want 01", halted);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if ({halted, halt} !== 3'b110) begin
          n_bad++;
          $display("FAIL halt_both_early: got halted=%b halt=%b, want halted=11 halt=0", halted, halt);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if ({halted, halt} !== 3'b111) begin
          n_bad++;
          $display("FAIL halt_both_late: got halted=%b halt=%b, want halted=11 halt=1", halted, halt);
        end
      end
      @(negedge clk);
    end
    clear_inputs();
    // reset must pull both threads out of HALT
    do_reset();
    n_cmp++;
    if ({issue_valid, issue_tid, issue_pc, halted, halt} !== {1'b1, 1'b0, 16'h0000, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL halt_reset_abort: got v=%b tid=%b pc=%h halted=%b halt=%b, want v=1 tid=0 pc=0000 halted=00 halt=0",
               issue_valid, issue_tid, issue_pc, halted, halt);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_wrap();
    test_priority();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
